fetch_cycle_bp: RTL
===================

Name: fetch_cycle_bp

Overview:
- Instruction-fetch stage with an integrated dynamic branch predictor. It sits directly upstream of the decode stage.
- Owns the PC register, a bimodal branch history table (BHT) of 2-bit saturating counters, and a direct-mapped branch target buffer (BTB).
- Owns the IF/ID pipeline register that drives InstrD, PCD, PCPlus4D and Predict_branchD into decode.
- Predictor state is trained from branch outcomes resolved in execute. The same interface carries the mispredict redirect.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IDX_BITS, 4, BHT/BTB index width; entries = 2**IDX_BITS; index = PC[IDX_BITS+1:2].
- NOP_INSTR, 32'h00000013, instruction injected into InstrD on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PCF  out  32  current fetch PC, sent to instruction memory.
- InstrF  in  32  instruction returned combinationally for PCF.
- StallF  in  1  hold PC register.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  load NOP bubble into IF/ID register.
- RedirectE  in  1  execute-detected misprediction or jump; take RedirectPCE next.
- RedirectPCE  in  32  correct next PC from execute.
- BranchE  in  1  a conditional branch is resolving in execute this cycle (train enable).
- TakenE  in  1  actual branch outcome.
- PCE  in  32  PC of the resolving branch.
- PCTargetE  in  32  computed target of the resolving branch.
- InstrD  out  32  registered instruction to decode.
- PCD  out  32  registered PC to decode.
- PCPlus4D  out  32  registered PC+4 to decode.
- Predict_branchD  out  1  registered prediction bit; decode carries it on as Predict_branchE.

Behaviour:
- Reset (rst=1 at edge):
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, Predict_branchD=0.
  - All BHT counters=2'b01 (weakly not-taken).
  - All BTB valid bits=0.
  - rst has priority over every other input, including mid-stall or mid-redirect.
- Prediction (combinational, from PCF):
  - idxF=PCF[IDX_BITS+1:2].
  - hit = BTB valid[idxF] && BTB tag[idxF]==PCF[31:IDX_BITS+2].
  - predict_taken = hit && BHT[idxF][1].
- Next PC, in priority order:
  - rst → RESET_PC
  - RedirectE → RedirectPCE (overrides StallF)
  - StallF → PCF unchanged
  - predict_taken → BTB target[idxF]
  - else → PCF+4, 32-bit wrap (32'hFFFFFFFC+4=0)
- IF/ID register, in priority order:
  - rst or FlushD → bubble (NOP_INSTR, zeros); FlushD overrides StallD.
  - StallD → hold all four outputs.
  - Else → load InstrF, PCF, PCF+4, predict_taken.
- Training (BranchE=1 at edge; ignored if rst):
  - idxE=PCE[IDX_BITS+1:2].
  - Counter increments if TakenE, decrements otherwise. It saturates at 2'b11 and 2'b00 with no wrap.
  - If TakenE: BTB[idxE] ← {valid=1, tag=PCE[31:IDX_BITS+2], target=PCTargetE}.
  - If not taken: the BTB entry is unchanged.
  - Training is independent of StallF/StallD/FlushD.
- Same-cycle read/write to the same index: the prediction uses the pre-update value (no bypass). The new value is visible the following cycle.
- Latency:
  - PC to IF/ID: 1 cycle.
  - Training to visible prediction: 1 cycle.
  - Redirect to new PCF: 1 cycle.
- Aliasing: a different PC with the same index but a different tag gives hit=0 → predict not-taken. The BHT counter is shared (no tag on the BHT).
- Storage: BHT/BTB are plain register arrays, no memory macros, and are resettable.

Test Plan:
- Reset then run, StallF=StallD=0, InstrF=32'h00500093:
  - PCF sequence is 0,4,8.
  - One cycle after PCF=4, InstrD=32'h00500093, PCD=4, PCPlus4D=8, Predict_branchD=0.
- Train: BranchE=1, TakenE=1, PCE=32'h20, PCTargetE=32'h100, for 1 cycle (counter 01→10):
  - When PCF later reaches 32'h20, the next PCF is 32'h100.
  - Predict_branchD=1 with PCD=32'h20.
- Saturation:
  - Four taken trainings at PCE=32'h20 leave counter=11.
  - One not-taken training leaves 10: still predicts taken.
  - A second not-taken training leaves 01: predicts not-taken, next PCF after 32'h20 is 32'h24.
- Alias: after training PCE=32'h20 taken, fetch PCF=32'h60 (same index, different tag):
  - Next PCF=32'h64, Predict_branchD=0.
- Hazard priority:
  - StallF=StallD=1 for 3 cycles: PCF and all D outputs hold.
  - StallD=1 with FlushD=1: InstrD=32'h00000013.
  - StallF=1 with RedirectE=1, RedirectPCE=32'h40: next PCF=32'h40.
- Reset mid-operation:
  - rst asserted while predict_taken=1 and RedirectE=1 gives next PCF=RESET_PC and InstrD=NOP.
  - Afterwards, the previously trained PC predicts not-taken (BTB invalidated).

Source files
------------

// File: rtl/fetch_cycle_bp.sv
// Instruction-fetch stage with bimodal branch prediction: PC register, BHT/BTB
// predictor trained from execute, and the IF/ID pipeline register.
module fetch_cycle_bp #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IDX_BITS  = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        Predict_branchD
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic [31:0]                      r_pc;
    logic [31:0]                      r_instr_d;
    logic [31:0]                      r_pc_d;
    logic [31:0]                      r_pc_plus4_d;
    logic                             r_pred_d;

    logic [IDX_BITS-1:0]              w_idx_f;
    logic [IDX_BITS-1:0]              w_idx_e;
    logic [TAG_BITS-1:0]              w_tag_f;
    logic [TAG_BITS-1:0]              w_tag_e;
    logic [ENTRIES-1:0]               w_valid;
    logic [ENTRIES-1:0][1:0]          w_bht;
    logic [ENTRIES-1:0][TAG_BITS-1:0] w_tag;
    logic [ENTRIES-1:0][31:0]         w_target;
    logic                             w_hit;
    logic                             w_predict_taken;
    logic [31:0]                      w_pc_plus4;
    logic [31:0]                      w_pc_next;
    logic                             w_unused;

    assign w_idx_f    = r_pc[IDX_BITS+1:2];
    assign w_tag_f    = r_pc[31:IDX_BITS+2];
    assign w_idx_e    = PCE[IDX_BITS+1:2];
    assign w_tag_e    = PCE[31:IDX_BITS+2];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_unused   = &{1'b0, PCE[1:0]};

    // One predictor entry per index; each entry owns its counter and BTB slot.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_BITS-1:0] LP_IDX = IDX_BITS'(gi);

            logic [1:0]          r_bht;
            logic                r_valid;
            logic [TAG_BITS-1:0] r_tag;
            logic [31:0]         r_target;
            logic                w_we;

            assign w_we = BranchE && (w_idx_e == LP_IDX);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bht    <= 2'b01;
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= '0;
                end else if (w_we) begin
                    if (TakenE) begin
                        if (r_bht != 2'b11) r_bht <= r_bht + 2'd1;
                        r_valid  <= 1'b1;
                        r_tag    <= w_tag_e;
                        r_target <= PCTargetE;
                    end else if (r_bht != 2'b00) begin
                        r_bht <= r_bht - 2'd1;
                    end
                end
            end

            assign w_valid[gi]  = r_valid;
            assign w_bht[gi]    = r_bht;
            assign w_tag[gi]    = r_tag;
            assign w_target[gi] = r_target;
        end
    endgenerate

    // Reads see the registered (pre-training) entry, so there is no bypass.
    assign w_hit           = w_valid[w_idx_f] && (w_tag[w_idx_f] == w_tag_f);
    assign w_predict_taken = w_hit && w_bht[w_idx_f][1];

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (RedirectE)            w_pc_next = RedirectPCE;
        else if (StallF)          w_pc_next = r_pc;
        else if (w_predict_taken) w_pc_next = w_target[w_idx_f];
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_pred_d     <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_pred_d     <= w_predict_taken;
        end
    end

    assign PCF             = r_pc;
    assign InstrD          = r_instr_d;
    assign PCD             = r_pc_d;
    assign PCPlus4D        = r_pc_plus4_d;
    assign Predict_branchD = r_pred_d;

endmodule
